nbit_updown_counter: RTL and testbench
======================================

# nbit_updown_counter

Parametrised synchronous up/down binary counter: the next generation of the team's fixed 4-bit counter. Adds a configurable width, a programmable modulus (terminal value), cascade enables, a saturate-at-terminal mode and a separate terminal-count flag. It keeps the parallel-load, asynchronous clear and active-low ripple-carry behaviour, so wide or decade counters can be built by cascading instances.

## Interface
- WIDTH, 8: counter width in bits, 1 to 32.
- MOD_MAX, 2**WIDTH-1: terminal value. Counter range is 0..MOD_MAX; must be 1..2**WIDTH-1.

- CP  in  1  clock, rising edge active.
- CLR_n  in  1  reset. Asynchronous, active-low; forces the counter to 0.
- M  in  1  direction: 1 = count up, 0 = count down.
- D  in  WIDTH  parallel load data.
- LD_n  in  1  synchronous load, active-low.
- EN_n  in  1  local count enable, active-low.
- CI_n  in  1  cascade carry-in, active-low; tie to 0 when the instance is stand-alone.
- SAT  in  1  1 = saturate at the terminal value; 0 = wrap around.
- Q  out  WIDTH  count value.
- TC  out  1  terminal count: high when Q equals the terminal value for the current M (MOD_MAX if up, 0 if down). Independent of the enables.
- Qcc_n  out  1  ripple carry out, active-low: low when TC=1, EN_n=0 and CI_n=0. Combinational; drives CI_n of the next stage.

## Operation
Priority, highest first:
1. CLR_n=0 (asynchronous): Q←0 immediately; the clock is ignored while CLR_n is held low.
2. LD_n=0 at a CP rising edge: Q←D, or Q←MOD_MAX if D>MOD_MAX (clamped). Load ignores EN_n, CI_n and SAT.
3. Count enable (EN_n=0 and CI_n=0) at a CP rising edge:
   - Up, Q<MOD_MAX: Q←Q+1.
   - Up, Q=MOD_MAX: Q←0 if SAT=0; Q holds if SAT=1.
   - Down, Q>0: Q←Q−1.
   - Down, Q=0: Q←MOD_MAX if SAT=0; Q holds if SAT=1.
4. Otherwise: Q holds.

- All arithmetic is WIDTH bits. The counter never produces a value above MOD_MAX; wrap is by comparison, not by natural overflow (unless MOD_MAX=2**WIDTH-1).
- M may change on any cycle. TC and Qcc_n re-evaluate combinationally against the new direction.
- Qcc_n stays low while saturated, as long as the enables are active, so downstream stages in SAT mode also see a carry. Cascades therefore use SAT=0 on every stage but the last.
- Reset state: Q=0, TC=(M==0), Qcc_n=~(TC & ~EN_n & ~CI_n).

## Timing
- Q is registered. It updates one CP rising edge after load or count conditions are sampled; there is zero added latency.
- TC and Qcc_n are combinational from Q, M, EN_n and CI_n. No register stage, so an N-stage cascade has N-deep combinational ripple on the carry.
- CLR_n assertion takes effect asynchronously. Deassertion is released synchronously inside the block with a 2-flop synchroniser on CP: the first count or load is honoured on the second rising edge after CLR_n goes high.
- LD_n and a count condition in the same cycle: load wins and no count occurs.
- CLR_n low mid-count or mid-load: Q=0 at once; a pending load is discarded.

## Test plan
WIDTH=4, MOD_MAX=9 unless stated.
- Reset/up wrap: CLR_n low for 1 cycle, then high, M=1, EN_n=CI_n=0, SAT=0.
  - Q goes 0,1,…,9,0.
  - TC=1 and Qcc_n=0 only while Q=9.
- Down wrap and saturate: load 2, M=0 → Q=2,1,0,9. Repeat with SAT=1 → Q=2,1,0,0,0 with TC=1 held.
- Load priority and clamp:
  - LD_n=0, D=4'b0111 with count enabled → Q=7 and held while LD_n stays low.
  - D=4'b1111 → Q=9 (clamped).
- Enables:
  - EN_n=1 or CI_n=1 → Q frozen and Qcc_n=1 even at Q=9.
  - Toggling M at Q=9 (up) → TC falls; at Q=0 (down) TC rises.
- Async clear mid-run: CLR_n pulsed low between clock edges at Q=6 → Q=0 before the next edge; counting resumes on the second edge after release.
- Cascade: two instances (WIDTH=4, MOD_MAX=9), with low-stage Qcc_n driving high-stage CI_n, count up 100 edges from 0.
  - Pair reads 00→99→00.
  - High stage advances only on the edge where the low stage is at 9.

Source files
------------

// File: rtl/nbit_updown_counter.sv
// nbit_updown_counter
//
// Parametrised synchronous up/down binary counter with a programmable
// terminal value, cascade enables, a saturate mode, parallel load,
// asynchronous clear and an active-low ripple-carry output.
//
// Parameters
//   WIDTH    counter width in bits (1..32)
//   MOD_MAX  terminal value; the counter range is 0..MOD_MAX
//
// Ports
//   CP     in   clock, rising edge active
//   CLR_n  in   asynchronous active-low clear, released synchronously
//   M      in   direction: 1 = up, 0 = down
//   D      in   parallel load data (clamped to MOD_MAX)
//   LD_n   in   synchronous load, active-low, highest synchronous priority
//   EN_n   in   local count enable, active-low
//   CI_n   in   cascade carry-in, active-low
//   SAT    in   1 = saturate at terminal value, 0 = wrap
//   Q      out  count value (registered)
//   TC     out  terminal count for the current direction (combinational)
//   Qcc_n  out  ripple carry out, active-low (combinational)

module nbit_updown_counter #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] MOD_MAX = {WIDTH{1'b1}}
) (
  input  logic             CP,
  input  logic             CLR_n,
  input  logic             M,
  input  logic [WIDTH-1:0] D,
  input  logic             LD_n,
  input  logic             EN_n,
  input  logic             CI_n,
  input  logic             SAT,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             Qcc_n
);

  logic             armed;
  logic             count_en;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q_next;

  assign at_max   = (Q == MOD_MAX);
  assign at_zero  = (Q == '0);
  assign count_en = ~EN_n & ~CI_n;

  assign TC    = M ? at_max : at_zero;
  assign Qcc_n = ~(TC & count_en);

  // Compared one bit wider so the test stays meaningful when MOD_MAX is
  // the all-ones value of WIDTH bits.
  assign load_val = ({1'b0, D} > {1'b0, MOD_MAX}) ? MOD_MAX : D;

  always_comb begin
    q_next = Q;
    if (!LD_n) begin
      q_next = load_val;
    end else if (count_en) begin
      if (M) begin
        if (at_max) begin
          q_next = SAT ? Q : '0;
        end else begin
          q_next = Q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          q_next = SAT ? Q : MOD_MAX;
        end else begin
          q_next = Q - WIDTH'(1);
        end
      end
    end
  end

  // Clear release is synchronised: the armed flop is the first stage and
  // the Q register (gated by armed) is the second, so the first edge after
  // CLR_n rises is ignored and the second edge honours a load or count.
  always_ff @(posedge CP or negedge CLR_n) begin
    if (!CLR_n) begin
      armed <= 1'b0;
      Q     <= '0;
    end else begin
      armed <= 1'b1;
      if (armed) begin
        Q <= q_next;
      end
    end
  end

endmodule

// File: tb/tb_nbit_updown_counter.sv
module tb_nbit_updown_counter;

  logic       cp = 1'b0;
  logic       clr_n, m, ld_n, en_n, ci_n, sat, hi_en_n;
  logic [3:0] d;
  logic [3:0] q_lo, q_hi;
  logic       tc_lo, tc_hi, qcc_lo, qcc_hi;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      nm;
    logic [3:0] q;
    logic       tc;
    logic       qcc;
    logic [3:0] qh;
  } exp_t;

  exp_t sb[$];

  always #5 cp = ~cp;

  nbit_updown_counter #(.WIDTH(4), .MOD_MAX(4'd9)) u_lo (
    .CP(cp), .CLR_n(clr_n), .M(m), .D(d), .LD_n(ld_n), .EN_n(en_n),
    .CI_n(ci_n), .SAT(sat), .Q(q_lo), .TC(tc_lo), .Qcc_n(qcc_lo)
  );

  nbit_updown_counter #(.WIDTH(4), .MOD_MAX(4'd9)) u_hi (
    .CP(cp), .CLR_n(clr_n), .M(m), .D(4'd0), .LD_n(1'b1), .EN_n(hi_en_n),
    .CI_n(qcc_lo), .SAT(1'b0), .Q(q_hi), .TC(tc_hi), .Qcc_n(qcc_hi)
  );

  task automatic tick();
    @(negedge cp);
    #1;
  endtask

  // Expected state at the next falling edge, after the coming rising edge.
  task automatic expect_st(input string nm, input logic [3:0] q, input logic tc,
                           input logic qcc, input logic [3:0] qh);
    exp_t e;
    e.nm = nm; e.q = q; e.tc = tc; e.qcc = qcc; e.qh = qh;
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge cp);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (q_lo !== e.q) begin
          errors++;
          $display("FAIL %s Q: got %0d expected %0d", e.nm, q_lo, e.q);
        end
        checks++;
        if (tc_lo !== e.tc) begin
          errors++;
          $display("FAIL %s TC: got %b expected %b (Q=%0d)", e.nm, tc_lo, e.tc, q_lo);
        end
        checks++;
        if (qcc_lo !== e.qcc) begin
          errors++;
          $display("FAIL %s Qcc_n: got %b expected %b (Q=%0d)", e.nm, qcc_lo, e.qcc, q_lo);
        end
        checks++;
        if (q_hi !== e.qh) begin
          errors++;
          $display("FAIL %s Q_hi: got %0d expected %0d (Q_lo=%0d)", e.nm, q_hi, e.qh, q_lo);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] v;
    clr_n = 1'b0; m = 1'b1; d = 4'd0; ld_n = 1'b1;
    en_n = 1'b0; ci_n = 1'b0; sat = 1'b0; hi_en_n = 1'b1;

    // reset state, both directions
    tick(); expect_st("reset_up", 4'd0, 1'b0, 1'b1, 4'd0);
    tick(); m = 1'b0; expect_st("reset_dn", 4'd0, 1'b1, 1'b0, 4'd0);

    // release: first edge ignored, then count 1..9,0
    tick(); clr_n = 1'b1; m = 1'b1; expect_st("release", 4'd0, 1'b0, 1'b1, 4'd0);
    for (int i = 1; i <= 10; i++) begin
      v = 4'(i % 10);
      tick(); expect_st("up_wrap", v, (v == 4'd9), (v != 4'd9), 4'd0);
    end

    // down wrap
    tick(); ld_n = 1'b0; d = 4'd2; m = 1'b0; expect_st("dn_load", 4'd2, 1'b0, 1'b1, 4'd0);
    tick(); ld_n = 1'b1; expect_st("dn_wrap", 4'd1, 1'b0, 1'b1, 4'd0);
    tick(); expect_st("dn_wrap", 4'd0, 1'b1, 1'b0, 4'd0);
    tick(); expect_st("dn_wrap", 4'd9, 1'b0, 1'b1, 4'd0);

    // down saturate
    tick(); ld_n = 1'b0; d = 4'd2; sat = 1'b1; expect_st("sat_load", 4'd2, 1'b0, 1'b1, 4'd0);
    tick(); ld_n = 1'b1; expect_st("dn_sat", 4'd1, 1'b0, 1'b1, 4'd0);
    tick(); expect_st("dn_sat", 4'd0, 1'b1, 1'b0, 4'd0);
    tick(); expect_st("dn_sat", 4'd0, 1'b1, 1'b0, 4'd0);
    tick(); expect_st("dn_sat", 4'd0, 1'b1, 1'b0, 4'd0);

    // load priority over count, then clamp
    tick(); sat = 1'b0; m = 1'b1; ld_n = 1'b0; d = 4'b0111;
    expect_st("ld_prio", 4'd7, 1'b0, 1'b1, 4'd0);
    tick(); expect_st("ld_hold", 4'd7, 1'b0, 1'b1, 4'd0);
    tick(); expect_st("ld_hold", 4'd7, 1'b0, 1'b1, 4'd0);
    tick(); d = 4'b1111; expect_st("ld_clamp", 4'd9, 1'b1, 1'b0, 4'd0);

    // enables freeze the count and block the carry
    tick(); ld_n = 1'b1; en_n = 1'b1; expect_st("en_off", 4'd9, 1'b1, 1'b1, 4'd0);
    tick(); en_n = 1'b0; ci_n = 1'b1; expect_st("ci_off", 4'd9, 1'b1, 1'b1, 4'd0);
    tick(); ci_n = 1'b0; en_n = 1'b1; m = 1'b0; expect_st("m_dn_at9", 4'd9, 1'b0, 1'b1, 4'd0);
    tick(); m = 1'b1; expect_st("m_up_at9", 4'd9, 1'b1, 1'b1, 4'd0);
    tick(); ld_n = 1'b0; d = 4'd0; expect_st("ld_zero", 4'd0, 1'b0, 1'b1, 4'd0);
    tick(); ld_n = 1'b1; m = 1'b0; expect_st("m_dn_at0", 4'd0, 1'b1, 1'b1, 4'd0);
    tick(); m = 1'b1; expect_st("m_up_at0", 4'd0, 1'b0, 1'b1, 4'd0);

    // up saturate holds at terminal with carry still asserted
    tick(); ld_n = 1'b0; d = 4'd9; en_n = 1'b0; sat = 1'b1;
    expect_st("up_sat_ld", 4'd9, 1'b1, 1'b0, 4'd0);
    tick(); ld_n = 1'b1; expect_st("up_sat", 4'd9, 1'b1, 1'b0, 4'd0);
    tick(); expect_st("up_sat", 4'd9, 1'b1, 1'b0, 4'd0);

    // asynchronous clear between edges at Q=6
    tick(); sat = 1'b0; ld_n = 1'b0; d = 4'd6; expect_st("pre_clr", 4'd6, 1'b0, 1'b1, 4'd0);
    tick(); ld_n = 1'b1; clr_n = 1'b0; #2; clr_n = 1'b1;
    expect_st("async_clr", 4'd0, 1'b0, 1'b1, 4'd0);
    tick(); expect_st("resume", 4'd1, 1'b0, 1'b1, 4'd0);
    tick(); expect_st("resume", 4'd2, 1'b0, 1'b1, 4'd0);

    // cascade of two decade stages counting 00..99..00
    tick(); clr_n = 1'b0; expect_st("casc_clr", 4'd0, 1'b0, 1'b1, 4'd0);
    tick(); clr_n = 1'b1; hi_en_n = 1'b0; expect_st("casc_rel", 4'd0, 1'b0, 1'b1, 4'd0);
    for (int n = 1; n <= 100; n++) begin
      v = 4'(n % 10);
      tick(); expect_st("cascade", v, (v == 4'd9), (v != 4'd9), 4'((n / 10) % 10));
    end

    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
